// File: rtl/instr_register_pipe.sv
// Instruction register file: two-stage compute/commit write pipeline, combinational read.
// Define INSTR_REG_BYPASS_EN to forward a matching stage-2 result onto the read port.

package instr_register_pipe_pkg;
    typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
endpackage

module instr_register_pipe
    import instr_register_pipe_pkg::*;
#(
    parameter int  DEPTH    = 32,
    parameter int  OP_WIDTH = 32,
    localparam int RW       = 2 * OP_WIDTH,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_en,
    input  logic [AW-1:0]              write_pointer,
    input  opcode_t                    opcode,
    input  logic signed [OP_WIDTH-1:0] operand_a,
    input  logic signed [OP_WIDTH-1:0] operand_b,
    input  logic                       clear_en,
    input  logic [AW-1:0]              read_pointer,
    output opcode_t                    rd_opcode,
    output logic signed [OP_WIDTH-1:0] rd_op_a,
    output logic signed [OP_WIDTH-1:0] rd_op_b,
    output logic signed [RW-1:0]       rd_result,
    output logic                       rd_valid,
    output logic                       rd_div0,
    output logic                       rd_pending,
    output logic [CW-1:0]              valid_count,
    output logic                       full
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    // Stage 1: accepted write request
    logic                       s1_valid;
    logic [AW-1:0]              s1_addr;
    opcode_t                    s1_opc;
    logic signed [OP_WIDTH-1:0] s1_a;
    logic signed [OP_WIDTH-1:0] s1_b;

    // Stage 2: computed result awaiting commit
    logic                       s2_valid;
    logic [AW-1:0]              s2_addr;
    opcode_t                    s2_opc;
    logic signed [OP_WIDTH-1:0] s2_a;
    logic signed [OP_WIDTH-1:0] s2_b;
    logic signed [RW-1:0]       s2_result;
    logic                       s2_div0;

    opcode_t                    mem_opc    [DEPTH];
    logic signed [OP_WIDTH-1:0] mem_a      [DEPTH];
    logic signed [OP_WIDTH-1:0] mem_b      [DEPTH];
    logic signed [RW-1:0]       mem_result [DEPTH];
    logic                       mem_div0   [DEPTH];
    logic [DEPTH-1:0]           entry_valid;

    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] alu_result;
    logic                 alu_div0;
    logic                 commit;

    // Operands are widened first so every result, including MULT and the
    // most-negative / -1 quotient, is exact in RW bits.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        a_ext      = {{OP_WIDTH{s1_a[OP_WIDTH-1]}}, s1_a};
        b_ext      = {{OP_WIDTH{s1_b[OP_WIDTH-1]}}, s1_b};
        alu_result = '0;
        alu_div0   = 1'b0;
        case (s1_opc)
            ZERO:    alu_result = '0;
            PASSA:   alu_result = a_ext;
            PASSB:   alu_result = b_ext;
            ADD:     alu_result = a_ext + b_ext;
            SUB:     alu_result = a_ext - b_ext;
            MULT:    alu_result = a_ext * b_ext;
            DIV,
            MOD: begin
                if (s1_b == '0) begin
                    alu_div0 = 1'b1;
                end else if (s1_opc == DIV) begin
                    alu_result = a_ext / b_ext;
                end else begin
                    alu_result = a_ext % b_ext;
                end
            end
            default: alu_result = '0;
        endcase
    end

    // Out-of-range writes never enter the pipeline; clear flushes S2 but S1 still
    // accepts the write presented alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_opc    <= ZERO;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_valid  <= 1'b0;
            s2_addr   <= '0;
            s2_opc    <= ZERO;
            s2_a      <= '0;
            s2_b      <= '0;
            s2_result <= '0;
            s2_div0   <= 1'b0;
        end else begin
            s1_valid  <= load_en && ({1'b0, write_pointer} < DEPTH_W);
            s1_addr   <= write_pointer;
            s1_opc    <= opcode;
            s1_a      <= operand_a;
            s1_b      <= operand_b;
            s2_valid  <= s1_valid && !clear_en;
            s2_addr   <= s1_addr;
            s2_opc    <= s1_opc;
            s2_a      <= s1_a;
            s2_b      <= s1_b;
            s2_result <= alu_result;
            s2_div0   <= alu_div0;
        end
    end

    assign commit = s2_valid && !clear_en;

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the array is reset entry by entry because reset must leave every entry zeroed.
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_opc[i]    <= ZERO;
                mem_a[i]      <= '0;
                mem_b[i]      <= '0;
                mem_result[i] <= '0;
                mem_div0[i]   <= 1'b0;
            end
            entry_valid <= '0;
            valid_count <= '0;
        end else if (clear_en) begin
            entry_valid <= '0;
            valid_count <= '0;
        end else if (commit) begin
            mem_opc[s2_addr]     <= s2_opc;
            mem_a[s2_addr]       <= s2_a;
            mem_b[s2_addr]       <= s2_b;
            mem_result[s2_addr]  <= s2_result;
            mem_div0[s2_addr]    <= s2_div0;
            entry_valid[s2_addr] <= 1'b1;
            if (!entry_valid[s2_addr]) begin
                valid_count <= valid_count + CW'(1);
            end
        end
    end

    assign full = (valid_count == CW'(DEPTH));

    logic          rd_in_range;
    logic [AW-1:0] rd_idx;
    logic          s1_hit;
    logic          s2_hit;

    always_comb begin
        rd_in_range = ({1'b0, read_pointer} < DEPTH_W);
        rd_idx      = rd_in_range ? read_pointer : '0;
        s1_hit      = s1_valid && (s1_addr == read_pointer);
        s2_hit      = s2_valid && (s2_addr == read_pointer);
        rd_opcode   = ZERO;
        rd_op_a     = '0;
        rd_op_b     = '0;
        rd_result   = '0;
        rd_valid    = 1'b0;
        rd_div0     = 1'b0;
`ifdef INSTR_REG_BYPASS_EN
        rd_pending  = s1_hit;
        if (s2_hit && !s1_hit) begin
            rd_opcode = s2_opc;
            rd_op_a   = s2_a;
            rd_op_b   = s2_b;
            rd_result = s2_result;
            rd_valid  = 1'b1;
            rd_div0   = s2_div0;
        end else if (rd_in_range && entry_valid[rd_idx]) begin
            rd_opcode = mem_opc[rd_idx];
            rd_op_a   = mem_a[rd_idx];
            rd_op_b   = mem_b[rd_idx];
            rd_result = mem_result[rd_idx];
            rd_valid  = 1'b1;
            rd_div0   = mem_div0[rd_idx];
        end
`else
        rd_pending  = s1_hit || s2_hit;
        if (rd_in_range && entry_valid[rd_idx]) begin
            rd_opcode = mem_opc[rd_idx];
            rd_op_a   = mem_a[rd_idx];
            rd_op_b   = mem_b[rd_idx];
            rd_result = mem_result[rd_idx];
            rd_valid  = 1'b1;
            rd_div0   = mem_div0[rd_idx];
        end
`endif
    end

endmodule

// File: tb/tb_instr_register_pipe.sv
// Scoreboard bench for instr_register_pipe: a DEPTH=32 and a DEPTH=20 instance share stimulus;
// expectations are queued with their check cycle and compared by a negedge monitor.

module tb_instr_register_pipe;
    import instr_register_pipe_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               load_en;
    logic [4:0]         write_pointer;
    opcode_t            opcode;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;
    logic               clear_en;
    logic [4:0]         read_pointer;

    opcode_t            r_opc,  q_opc;
    logic signed [31:0] r_a,    q_a;
    logic signed [31:0] r_b,    q_b;
    logic signed [63:0] r_res,  q_res;
    logic               r_vld,  q_vld;
    logic               r_div0, q_div0;
    logic               r_pend, q_pend;
    logic [5:0]         r_cnt;
    logic [4:0]         q_cnt;
    logic               r_full, q_full;

    instr_register_pipe #(.DEPTH(32), .OP_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .write_pointer(write_pointer),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b), .clear_en(clear_en),
        .read_pointer(read_pointer), .rd_opcode(r_opc), .rd_op_a(r_a), .rd_op_b(r_b),
        .rd_result(r_res), .rd_valid(r_vld), .rd_div0(r_div0), .rd_pending(r_pend),
        .valid_count(r_cnt), .full(r_full)
    );

    instr_register_pipe #(.DEPTH(20), .OP_WIDTH(32)) dut20 (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .write_pointer(write_pointer),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b), .clear_en(clear_en),
        .read_pointer(read_pointer), .rd_opcode(q_opc), .rd_op_a(q_a), .rd_op_b(q_b),
        .rd_result(q_res), .rd_valid(q_vld), .rd_div0(q_div0), .rd_pending(q_pend),
        .valid_count(q_cnt), .full(q_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        bit          d20;
        opcode_t     opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic        vld;
        logic        div0;
        logic        pend;
        int          cnt;
        logic        full;
    } exp_t;

    typedef struct {
        logic [4:0]  addr;
        opcode_t     opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic        div0;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   tests    = 0;
    int   failures = 0;

    task automatic next();
        @(posedge clk);
        #1;
        load_en  = 1'b0;
        clear_en = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input opcode_t opc,
                      input logic [31:0] a, input logic [31:0] b);
        load_en       = 1'b1;
        write_pointer = addr;
        opcode        = opc;
        operand_a     = a;
        operand_b     = b;
    endtask

    task automatic expect_rd(input string name, input bit d20, input logic [4:0] ptr,
                             input opcode_t opc, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] res, input logic vld, input logic div0,
                             input logic pend, input int cnt, input logic full);
        exp_t e;
        read_pointer = ptr;
        e.cyc  = cyc;
        e.name = name;
        e.d20  = d20;
        e.opc  = opc;
        e.a    = a;
        e.b    = b;
        e.res  = res;
        e.vld  = vld;
        e.div0 = div0;
        e.pend = pend;
        e.cnt  = cnt;
        e.full = full;
        sb.push_back(e);
    endtask

    task automatic expect_empty(input string name, input bit d20, input logic [4:0] ptr,
                                input logic pend, input int cnt);
        expect_rd(name, d20, ptr, ZERO, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, pend, cnt, 1'b0);
    endtask

    // Monitor: compare every queued expectation whose check cycle has arrived
    initial begin
        exp_t        e;
        opcode_t     a_opc;
        logic [31:0] a_a, a_b;
        logic [63:0] a_res;
        logic        a_vld, a_div0, a_pend, a_full;
        int          a_cnt;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e      = sb.pop_front();
                a_opc  = e.d20 ? q_opc  : r_opc;
                a_a    = e.d20 ? q_a    : r_a;
                a_b    = e.d20 ? q_b    : r_b;
                a_res  = e.d20 ? q_res  : r_res;
                a_vld  = e.d20 ? q_vld  : r_vld;
                a_div0 = e.d20 ? q_div0 : r_div0;
                a_pend = e.d20 ? q_pend : r_pend;
                a_full = e.d20 ? q_full : r_full;
                a_cnt  = e.d20 ? int'(q_cnt) : int'(r_cnt);
                tests++;
                if (e.cyc != cyc || a_opc !== e.opc || a_a !== e.a || a_b !== e.b ||
                    a_res !== e.res || a_vld !== e.vld || a_div0 !== e.div0 ||
                    a_pend !== e.pend || a_cnt != e.cnt || a_full !== e.full) begin
                    failures++;
                    $display("FAIL %s @cyc %0d (due %0d): got opc=%0d a=%h b=%h res=%h vld=%b div0=%b pend=%b cnt=%0d full=%b, expected opc=%0d a=%h b=%h res=%h vld=%b div0=%b pend=%b cnt=%0d full=%b",
                             e.name, cyc, e.cyc, a_opc, a_a, a_b, a_res, a_vld, a_div0, a_pend, a_cnt, a_full,
                             e.opc, e.a, e.b, e.res, e.vld, e.div0, e.pend, e.cnt, e.full);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations still queued", sb.size());
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5'd0,  DIV,   32'd9,         32'd0,         64'd0,                  1'b1};
        vecs[1] = '{5'd1,  MOD,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[2] = '{5'd2,  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0};
        vecs[3] = '{5'd6,  DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[4] = '{5'd8,  MULT,  32'hFFFF_FFFD, 32'h7FFF_FFFF, 64'hFFFF_FFFE_8000_0003, 1'b0};
        vecs[5] = '{5'd9,  SUB,   32'h8000_0000, 32'd1,         64'hFFFF_FFFF_7FFF_FFFF, 1'b0};
        vecs[6] = '{5'd10, PASSB, 32'd123,       32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
        vecs[7] = '{5'd11, ZERO,  32'd5,         32'd6,         64'd0,                  1'b0};
        vecs[8] = '{5'd13, MOD,   32'hFFFF_FFF7, 32'd0,         64'd0,                  1'b1};
        vecs[9] = '{5'd14, MOD,   32'd7,         32'hFFFF_FFFE, 64'd1,                  1'b0};

        reset_n       = 1'b0;
        load_en       = 1'b0;
        clear_en      = 1'b0;
        write_pointer = '0;
        opcode        = ZERO;
        operand_a     = '0;
        operand_b     = '0;
        read_pointer  = '0;

        // Reset state
        next();
        expect_empty("reset_state", 0, 5'd0, 1'b0, 0);
        expect_empty("reset_state_d20", 1, 5'd0, 1'b0, 0);
        next();
        reset_n = 1'b1;
        next();

        // ADD to addr 3, latency 2
        wr(5'd3, ADD, 32'hFFFF_FFF9, 32'd5);
        next();
        expect_empty("add_in_s1", 0, 5'd3, 1'b1, 0);
        next();
        next();
        expect_rd("add_commit", 0, 5'd3, ADD, 32'hFFFF_FFF9, 32'd5, 64'hFFFF_FFFF_FFFF_FFFE,
                  1'b1, 1'b0, 1'b0, 1, 1'b0);

        // Back-to-back ALU vectors including divide-by-zero and overflow edges
        foreach (vecs[i]) begin
            next();
            wr(vecs[i].addr, vecs[i].opc, vecs[i].a, vecs[i].b);
        end
        next();
        next();
        next();
        foreach (vecs[i]) begin
            expect_rd($sformatf("alu_vec%0d", i), 0, vecs[i].addr, vecs[i].opc, vecs[i].a, vecs[i].b,
                      vecs[i].res, 1'b1, vecs[i].div0, 1'b0, 11, 1'b0);
            next();
        end

        // Same-address writes commit in order; overwrite does not bump the count
        wr(5'd12, PASSA, 32'd100, 32'd0);
        next();
        wr(5'd12, PASSA, 32'd200, 32'd0);
        next();
        next();
        next();
        expect_rd("last_write_wins", 0, 5'd12, PASSA, 32'd200, 32'd0, 64'd200, 1'b1, 1'b0, 1'b0, 12, 1'b0);
        next();

        // MULT to addr 5 with read held on 5
        wr(5'd5, MULT, 32'd3, 32'd4);
        next();
        expect_empty("mult_in_s1", 0, 5'd5, 1'b1, 12);
        next();
`ifdef INSTR_REG_BYPASS_EN
        expect_rd("mult_in_s2", 0, 5'd5, MULT, 32'd3, 32'd4, 64'd12, 1'b1, 1'b0, 1'b0, 12, 1'b0);
`else
        expect_empty("mult_in_s2", 0, 5'd5, 1'b1, 12);
`endif
        next();
        expect_rd("mult_commit", 0, 5'd5, MULT, 32'd3, 32'd4, 64'd12, 1'b1, 1'b0, 1'b0, 13, 1'b0);
        next();

        // Fill all 32 entries
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), ADD, 32'(i), 32'd1);
            next();
        end
        next();
        next();
        expect_rd("fill_full", 0, 5'd31, ADD, 32'd31, 32'd1, 64'd32, 1'b1, 1'b0, 1'b0, 32, 1'b1);
        next();
        wr(5'd7, ADD, 32'd70, 32'd0);
        next();
        next();
        next();
        expect_rd("full_overwrite", 0, 5'd7, ADD, 32'd70, 32'd0, 64'd70, 1'b1, 1'b0, 1'b0, 32, 1'b1);
        next();

        // Clear flushes the in-flight write to 20 but accepts the concurrent write to 2
        wr(5'd20, ADD, 32'd1, 32'd1);
        next();
        wr(5'd2, SUB, 32'd10, 32'd3);
        clear_en = 1'b1;
        next();
        expect_empty("clear_count0", 0, 5'd2, 1'b1, 0);
        next();
        next();
        expect_rd("clear_with_load", 0, 5'd2, SUB, 32'd10, 32'd3, 64'd7, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        next();
        expect_empty("clear_flushed_s1", 0, 5'd20, 1'b0, 1);
        next();

        // Reset asserted while a write is in flight
        wr(5'd4, ADD, 32'd1, 32'd2);
        next();
        reset_n = 1'b0;
        expect_empty("reset_async", 0, 5'd4, 1'b0, 0);
        next();
        reset_n = 1'b1;
        next();
        next();
        expect_empty("reset_midwrite", 0, 5'd4, 1'b0, 0);
        next();

        // Out-of-range address on the DEPTH=20 instance
        wr(5'd25, PASSA, 32'd55, 32'd0);
        next();
        expect_empty("oor_s1_d20", 1, 5'd25, 1'b0, 0);
        expect_empty("inrange_s1_d32", 0, 5'd25, 1'b1, 0);
        next();
        next();
        expect_empty("oor_dropped_d20", 1, 5'd25, 1'b0, 0);
        expect_rd("inrange_commit_d32", 0, 5'd25, PASSA, 32'd55, 32'd0, 64'd55, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        next();
        wr(5'd19, ADD, 32'd2, 32'd3);
        next();
        next();
        next();
        expect_rd("top_entry_d20", 1, 5'd19, ADD, 32'd2, 32'd3, 64'd5, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        next();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            tests++;
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
